// File: rtl/q_debounce_edge_if.sv
// Bus bundle for q_debounce_edge: sampled input and clear toward the debouncer,
// debounced level, strobes and rise count back from it.
interface q_debounce_edge_if #(
  parameter int CNT_W = 8
);
  logic             d_in;
  logic             clear;
  logic             level;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] edge_count;

  modport master (
    output d_in,
    output clear,
    input  level,
    input  rise,
    input  fall,
    input  edge_count
  );

  modport slave (
    input  d_in,
    input  clear,
    output level,
    output rise,
    output fall,
    output edge_count
  );
endinterface

// File: rtl/q_debounce_edge.sv
// Glitch filter for a registered Q stream: clean level, rise/fall strobes, rise counter.
// Define DEBOUNCE_CNT_SAT_EN to make edge_count saturate instead of wrapping.
module q_debounce_edge #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input logic              clk,
  input logic              reset,
  q_debounce_edge_if.slave bus
);

  typedef enum logic [1:0] {
    LOW,
    CHK_HI,
    HIGH,
    CHK_LO
  } state_t;

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  localparam bit         DIRECT = (STABLE_CYCLES == 1);

  state_t           state;
  logic             s;
  logic [7:0]       cnt;
  logic             level_r;
  logic             rise_r;
  logic             fall_r;
  logic [CNT_W-1:0] count_r;

  logic             window_done;
  logic             go_high;
  logic [CNT_W-1:0] count_inc;

  // The window is complete when this sample would be the STABLE-th differing one.
  always_comb begin
    window_done = ((cnt + 8'd1) == STABLE);
    go_high     = s && (((state == LOW) && DIRECT) || ((state == CHK_HI) && window_done));
  end

  always_comb begin
`ifdef DEBOUNCE_CNT_SAT_EN
    count_inc = (count_r == {CNT_W{1'b1}}) ? count_r : count_r + CNT_W'(1);
`else
    count_inc = count_r + CNT_W'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= LOW;
      s       <= 1'b0;
      cnt     <= 8'd0;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      count_r <= '0;
    end else begin
      s      <= bus.d_in;
      rise_r <= 1'b0;
      fall_r <= 1'b0;

      if (bus.clear) begin
        count_r <= '0;
      end else if (go_high) begin
        count_r <= count_inc;
      end

      case (state)
        LOW: begin
          if (s) begin
            if (DIRECT) begin
              state   <= HIGH;
              level_r <= 1'b1;
              rise_r  <= 1'b1;
            end else begin
              state <= CHK_HI;
              cnt   <= 8'd1;
            end
          end
        end

        CHK_HI: begin
          if (!s) begin
            state <= LOW;
            cnt   <= 8'd0;
          end else if (window_done) begin
            state   <= HIGH;
            level_r <= 1'b1;
            rise_r  <= 1'b1;
            cnt     <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        HIGH: begin
          if (!s) begin
            if (DIRECT) begin
              state   <= LOW;
              level_r <= 1'b0;
              fall_r  <= 1'b1;
            end else begin
              state <= CHK_LO;
              cnt   <= 8'd1;
            end
          end
        end

        CHK_LO: begin
          if (s) begin
            state <= HIGH;
            cnt   <= 8'd0;
          end else if (window_done) begin
            state   <= LOW;
            level_r <= 1'b0;
            fall_r  <= 1'b1;
            cnt     <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        default: begin
          state <= LOW;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

  assign bus.level      = level_r;
  assign bus.rise       = rise_r;
  assign bus.fall       = fall_r;
  assign bus.edge_count = count_r;

endmodule

// File: tb/tb_q_debounce_edge.sv
// Bench for q_debounce_edge: one instance with a 4-cycle window and one with a
// 1-cycle window, both compared every cycle against a sample-history model.
module tb_q_debounce_edge;

  localparam int W    = 4;
  localparam int MAXC = (1 << W) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic d_in  = 1'b0;
  logic clear = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  q_debounce_edge_if #(.CNT_W(W)) bus0 ();
  q_debounce_edge_if #(.CNT_W(W)) bus1 ();

  assign bus0.d_in  = d_in;
  assign bus0.clear = clear;
  assign bus1.d_in  = d_in;
  assign bus1.clear = clear;

  q_debounce_edge #(.STABLE_CYCLES(4), .CNT_W(W)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  q_debounce_edge #(.STABLE_CYCLES(1), .CNT_W(W)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  // Model: level flips once the last N captured samples all differ from it.
  int       m_n     [2];
  bit       m_level [2];
  bit       m_rise  [2];
  bit       m_fall  [2];
  int       m_count [2];
  bit [7:0] m_hist  [2];
  int       m_fill  [2];

  function automatic bit window_differs(bit [7:0] h, int n, bit lvl);
    for (int i = 0; i < n; i++) begin
      if (h[i] == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_level[i] = 1'b0;
        m_rise[i]  = 1'b0;
        m_fall[i]  = 1'b0;
        m_count[i] = 0;
        m_hist[i]  = 8'd0;
        m_fill[i]  = 0;
      end else begin
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (m_fill[i] >= m_n[i] && window_differs(m_hist[i], m_n[i], m_level[i])) begin
          m_level[i] = !m_level[i];
          if (m_level[i]) m_rise[i] = 1'b1;
          else            m_fall[i] = 1'b1;
        end
        if (clear) begin
          m_count[i] = 0;
        end else if (m_rise[i]) begin
`ifdef DEBOUNCE_CNT_SAT_EN
          if (m_count[i] < MAXC) m_count[i] = m_count[i] + 1;
`else
          m_count[i] = (m_count[i] + 1) % (MAXC + 1);
`endif
        end
        m_hist[i] = {m_hist[i][6:0], d_in};
        if (m_fill[i] < 8) m_fill[i] = m_fill[i] + 1;
      end
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic compare_all();
    check_output("n4_level", 32'(bus0.level),      32'(m_level[0]));
    check_output("n4_rise",  32'(bus0.rise),       32'(m_rise[0]));
    check_output("n4_fall",  32'(bus0.fall),       32'(m_fall[0]));
    check_output("n4_count", 32'(bus0.edge_count), 32'(m_count[0]));
    check_output("n1_level", 32'(bus1.level),      32'(m_level[1]));
    check_output("n1_rise",  32'(bus1.rise),       32'(m_rise[1]));
    check_output("n1_fall",  32'(bus1.fall),       32'(m_fall[1]));
    check_output("n1_count", 32'(bus1.edge_count), 32'(m_count[1]));
  endtask

  task automatic apply_stimulus(input bit d, input bit c, input bit r);
    d_in  = d;
    clear = c;
    reset = r;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  bit v;
  int len;

  initial begin
    m_n[0] = 4;
    m_n[1] = 1;
    for (int i = 0; i < 2; i++) begin
      m_level[i] = 1'b0;
      m_rise[i]  = 1'b0;
      m_fall[i]  = 1'b0;
      m_count[i] = 0;
      m_hist[i]  = 8'd0;
      m_fill[i]  = 0;
    end

    // Reset held with d_in high, then release: rise four edges after first capture.
    repeat (3) apply_stimulus(1'b1, 1'b0, 1'b1);
    check_output("reset_level", 32'(bus0.level), 32'd0);
    check_output("reset_rise", 32'(bus0.rise), 32'd0);
    check_output("reset_count", 32'(bus0.edge_count), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0);
      check_output($sformatf("release_rise_%0d", k), 32'(bus0.rise), (k == 5) ? 32'd1 : 32'd0);
    end
    check_output("release_count", 32'(bus0.edge_count), 32'd1);

    repeat (8) apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("low_level", 32'(bus0.level), 32'd0);

    // Three-cycle glitch must be swallowed.
    repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0);
    repeat (6) apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("glitch_level", 32'(bus0.level), 32'd0);
    check_output("glitch_count", 32'(bus0.edge_count), 32'd1);

    repeat (10) apply_stimulus(1'b1, 1'b0, 1'b0);
    repeat (10) apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("toggle_count", 32'(bus0.edge_count), 32'd2);

    // Reset in the middle of a rising window.
    repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b1);
    repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0);
    repeat (6) apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("midreset_level", 32'(bus0.level), 32'd0);
    check_output("midreset_count", 32'(bus0.edge_count), 32'd0);

    // Five rises, then clear on the same edge as the sixth.
    repeat (5) begin
      repeat (5) apply_stimulus(1'b1, 1'b0, 1'b0);
      repeat (5) apply_stimulus(1'b0, 1'b0, 1'b0);
    end
    check_output("pre_clear_count", 32'(bus0.edge_count), 32'd5);
    repeat (4) apply_stimulus(1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("collide_rise", 32'(bus0.rise), 32'd1);
    check_output("collide_count", 32'(bus0.edge_count), 32'd0);
    repeat (6) apply_stimulus(1'b0, 1'b0, 1'b0);

    // Seventeen rises into a 4-bit counter.
    apply_stimulus(1'b0, 1'b0, 1'b1);
    repeat (17) begin
      repeat (5) apply_stimulus(1'b1, 1'b0, 1'b0);
      repeat (5) apply_stimulus(1'b0, 1'b0, 1'b0);
    end
`ifdef DEBOUNCE_CNT_SAT_EN
    check_output("overflow_count", 32'(bus0.edge_count), 32'd15);
`else
    check_output("overflow_count", 32'(bus0.edge_count), 32'd1);
`endif

    // Random runs of varying length with occasional clear and reset.
    for (int k = 0; k < 80; k++) begin
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++) begin
        apply_stimulus(v, $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
